// File: rtl/load_unit_mc.sv
// rtl/load_unit_mc.sv - multi-cycle load unit: aligned fetch, extract, sign/zero extend.
// Optional macro MISALIGN_SPLIT_EN splits misaligned loads into two memory beats.
module load_unit_mc #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err
);

    localparam int BUS_B = XLEN / 8;
    localparam int OFF_W = $clog2(BUS_B);
    localparam int SW    = OFF_W + 2;
    localparam int SHW   = $clog2(2 * XLEN);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    state_t            state, next_state;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
`ifdef MISALIGN_SPLIT_EN
    logic              misal_q;
    logic [XLEN-1:0]   beat0;
`endif

    logic              req_legal;
    logic [OFF_W-1:0]  req_off;
    logic [SW-1:0]     req_size;
    logic [SW-1:0]     req_sum;
    logic              req_misal;
    logic [ADDR_W-1:0] req_aligned;

    assign req_off     = req_addr[OFF_W-1:0];
    assign req_size    = SW'(1) << req_funct3[1:0];
    assign req_sum     = {2'b00, req_off} + req_size;
    assign req_misal   = req_sum > SW'(BUS_B);
    assign req_aligned = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
            3'b011, 3'b110:                         req_legal = (XLEN == 64);
            default:                                req_legal = 1'b0;
        endcase
    end

    // Shift the two-beat window down to the addressed byte, then fill above the loaded size.
    function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] cat,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [2:0]        f3);
        logic [2*XLEN-1:0] sh;
        logic [SHW-1:0]    top;
        logic              fill;
        logic [XLEN-1:0]   r;
        sh = cat >> {off, 3'b000};
        case (f3[1:0])
            2'd0:    top = SHW'(7);
            2'd1:    top = SHW'(15);
            2'd2:    top = SHW'(31);
            default: top = SHW'(63);
        endcase
        fill = f3[2] ? 1'b0 : sh[top];
        for (int i = 0; i < XLEN; i++) begin
            r[i] = (SHW'(i) <= top) ? sh[i] : fill;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        mem_req    = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
`ifdef MISALIGN_SPLIT_EN
                    next_state = req_legal ? RD0 : RESP;
`else
                    next_state = (req_legal && !req_misal) ? RD0 : RESP;
`endif
                end
            end
            RD0: begin
                mem_req = 1'b1;
                if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    next_state = misal_q ? RD1 : RESP;
`else
                    next_state = RESP;
`endif
                end
            end
`ifdef MISALIGN_SPLIT_EN
            RD1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    next_state = RESP;
                end
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q      <= 3'b000;
            off_q     <= '0;
            mem_addr  <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            misal_q   <= 1'b0;
            beat0     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        f3_q  <= req_funct3;
                        off_q <= req_off;
`ifdef MISALIGN_SPLIT_EN
                        misal_q <= req_misal;
`endif
                        if (next_state == RESP) begin
                            resp_data <= '0;
                            resp_err  <= 1'b1;
                        end else begin
                            mem_addr <= req_aligned;
                        end
                    end
                end
                RD0: begin
                    if (mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                        if (misal_q) begin
                            beat0    <= mem_rdata;
                            mem_addr <= mem_addr + ADDR_W'(BUS_B);
                        end else
`endif
                        begin
                            resp_data <= extract({{XLEN{1'b0}}, mem_rdata}, off_q, f3_q);
                            resp_err  <= 1'b0;
                        end
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                RD1: begin
                    if (mem_ack) begin
                        resp_data <= extract({mem_rdata, beat0}, off_q, f3_q);
                        resp_err  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
